req_arbiter4: RTL and testbench

Sequential 4-way arbiter that shares a single downstream resource between four requesters. It supports fixed priority, with index 0 highest (the same ordering as the team's combinational priority encoder), and round-robin priority. A grant is held until the owner signals completion, drops its request, or exceeds a hold-time limit. The block sits between the requester ports and the shared datapath, and drives its one-hot select and its encoded owner index.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_pick.sv | 35 +++
 rtl/req_arbiter4.sv | 121 ++++++++++++
 tb/tb_req_arbiter4.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way request arbiter.
// Holds the FSM state encoding and the requester count/index width.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: lowest-index-first priority encoding,
// rotated to start at ptr when mode=1 (round-robin), unrotated when mode=0.
module arb_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               mode,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    id
);

    logic [ID_W-1:0]      w_base;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W-1:0]      w_off;

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // value just computed; every output gets a default first, so no latch.
    always_comb begin
        w_base = mode ? ptr : '0;
        w_dbl  = {req, req} >> w_base;
        w_rot  = w_dbl[NUM_REQ-1:0];
        w_off  = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_W'(i);
            end
        end
        id     = w_base + w_off;
        onehot = (|req) ? (NUM_REQ'(1) << id) : '0;
    end

endmodule

// File: rtl/req_arbiter4.sv
// Sequential 4-way arbiter with fixed/round-robin priority, grant hold until
// done, owner drop or hold-time limit, and a one-cycle GAP after each release.
module req_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic               mode,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [ID_W-1:0]    r_id;
    logic               r_valid;
    logic               r_timeout;

    state_t             w_state_nx;
    logic [ID_W-1:0]    w_ptr_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [NUM_REQ-1:0] w_gnt_nx;
    logic [ID_W-1:0]    w_id_nx;
    logic               w_valid_nx;
    logic               w_timeout_nx;
    logic               w_release;
    logic               w_hold_hit;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [ID_W-1:0]    w_pick_id;

    arb_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .mode   (mode),
        .onehot (w_pick_onehot),
        .id     (w_pick_id)
    );

    assign w_hold_hit = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);

    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_cnt_nx     = r_cnt;
        w_gnt_nx     = r_gnt;
        w_id_nx      = r_id;
        w_valid_nx   = r_valid;
        w_timeout_nx = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_gnt_nx   = w_pick_onehot;
                    w_id_nx    = w_pick_id;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = BUSY;
                end
            end
            BUSY: begin
                // done or owner drop take precedence, so timeout stays low then.
                if (done || !req[r_id]) begin
                    w_release = 1'b1;
                end else if (w_hold_hit) begin
                    w_release    = 1'b1;
                    w_timeout_nx = 1'b1;
                end else if (r_cnt != '1) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            GAP:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (w_release) begin
            w_gnt_nx   = '0;
            w_id_nx    = '0;
            w_valid_nx = 1'b0;
            w_ptr_nx   = r_id + 1'b1;
            w_state_nx = GAP;
        end
    end

    // NOTE: state uses non-blocking '<=' so every register samples pre-edge
    // values; reset is synchronous and covers all state, including the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_id      <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_cnt     <= w_cnt_nx;
            r_gnt     <= w_gnt_nx;
            r_id      <= w_id_nx;
            r_valid   <= w_valid_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_id;
    assign gnt_valid = r_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_req_arbiter4.sv
// Self-checking bench for req_arbiter4 (MAX_HOLD=4): a behavioural model feeds
// a scoreboard queue every cycle, plus directed checks of the test-plan cases.
module tb_req_arbiter4;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: 0=IDLE, 1=BUSY, 2=GAP.
    int         m_state = 0;
    int         m_ptr   = 0;
    int         m_cnt   = 0;
    int         m_id    = 0;
    logic       m_valid = 1'b0;
    logic       m_to    = 1'b0;

    logic [7:0] q_exp[$];
    int         rr_order[$];
    int         rr_gaps[$];

    req_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_release();
        m_ptr   = (m_id + 1) % 4;
        m_id    = 0;
        m_valid = 1'b0;
        m_state = 2;
    endtask

    task automatic model_edge(input logic r, input logic [3:0] rq, input logic d, input logic m);
        if (r) begin
            m_state = 0; m_ptr = 0; m_cnt = 0; m_id = 0; m_valid = 1'b0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            case (m_state)
                0: begin
                    if (rq != 4'b0000) begin
                        for (int k = 3; k >= 0; k--) begin
                            int idx;
                            idx = m ? (m_ptr + k) % 4 : k;
                            if (rq[idx]) m_id = idx;
                        end
                        m_valid = 1'b1;
                        m_cnt   = 0;
                        m_state = 1;
                    end
                end
                1: begin
                    if (d || !rq[m_id]) begin
                        model_release();
                    end else if (MH != 0 && m_cnt == MH - 1) begin
                        model_release();
                        m_to = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        g = m_valid ? (4'b0001 << m_id) : 4'b0000;
        return {m_to, m_valid, 2'(m_id), g};
    endfunction

    // Drive one cycle's inputs on the falling edge, predict, then compare #1
    // after the rising edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic d, input logic m);
        @(negedge clk);
        rst = r; req = rq; done = d; mode = m;
        model_edge(r, rq, d, m);
        q_exp.push_back(model_out());
        @(posedge clk);
        #1;
        check("cycle", {timeout, gnt_valid, gnt_id, gnt}, q_exp.pop_front());
    endtask

    initial begin
        int   held;
        int   zero_run;
        logic seen;
        logic prev_valid;
        logic to_at_drop;

        // Reset with all requests pending, then first grant to index 0.
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        check("rst_outs", {timeout, gnt_valid, gnt_id, gnt}, 8'h00);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 1'b0, 1'b0);
        check("rst_first_gnt", {4'h0, gnt}, 8'h01);

        // Fixed priority with req=1010: owner 1, done on the 3rd grant cycle.
        step(1'b0, 4'b1111, 1'b1, 1'b0);
        step(1'b0, 4'b1010, 1'b0, 1'b0);
        step(1'b0, 4'b1010, 1'b0, 1'b0);
        check("fix_gnt", {2'b0, gnt_id, gnt}, {2'b0, 2'd1, 4'b0010});
        step(1'b0, 4'b1010, 1'b0, 1'b0);
        step(1'b0, 4'b1010, 1'b0, 1'b0);
        step(1'b0, 4'b1010, 1'b1, 1'b0);
        check("fix_release", {7'b0, gnt_valid}, 8'h00);
        step(1'b0, 4'b1010, 1'b0, 1'b0);
        check("fix_gap", {4'h0, gnt}, 8'h00);
        step(1'b0, 4'b1010, 1'b0, 1'b0);
        check("fix_regrant", {4'h0, gnt}, 8'h02);

        // Round-robin from a fresh reset: order 0,1,2,3,0, two idle cycles between grants.
        step(1'b1, 4'b1111, 1'b0, 1'b1);
        prev_valid = gnt_valid;
        zero_run   = 0;
        seen       = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 4'b1111, 1'b1, 1'b1);
            if (gnt_valid && !prev_valid) begin
                rr_order.push_back(int'(gnt_id));
                if (seen) rr_gaps.push_back(zero_run);
                seen = 1'b1;
            end
            zero_run   = gnt_valid ? 0 : zero_run + 1;
            prev_valid = gnt_valid;
        end
        check("rr_count", 8'(rr_order.size()), 8'd5);
        for (int i = 0; i < rr_order.size() && i < 5; i++) begin
            check($sformatf("rr_order[%0d]", i), 8'(rr_order[i]), 8'(i % 4));
        end
        for (int i = 0; i < rr_gaps.size(); i++) begin
            check($sformatf("rr_gap[%0d]", i), 8'(rr_gaps[i]), 8'd2);
        end

        // Timeout: req=0100 held, grant visible exactly MAX_HOLD cycles.
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        check("to_gnt", {4'h0, gnt}, 8'h04);
        held       = 1;
        to_at_drop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0100, 1'b0, 1'b0);
            if (gnt == 4'b0100) begin
                held++;
            end else begin
                to_at_drop = timeout;
                break;
            end
        end
        check("to_held_cycles", 8'(held), 8'(MH));
        check("to_pulse", {7'b0, to_at_drop}, 8'h01);
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        check("to_pulse_end", {7'b0, timeout}, 8'h00);
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        check("to_regrant", {4'h0, gnt}, 8'h04);

        // done on the 4th grant cycle wins over the hold limit.
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 1'b0);
        check("tvd_valid", {7'b0, gnt_valid}, 8'h00);
        check("tvd_timeout", {7'b0, timeout}, 8'h00);

        // Owner 2 drops its request: release, then round-robin resumes at 3.
        step(1'b0, 4'b0100, 1'b0, 1'b1);
        step(1'b0, 4'b0100, 1'b0, 1'b1);
        check("drop_owner", {6'b0, gnt_id}, 8'h02);
        step(1'b0, 4'b1011, 1'b0, 1'b1);
        check("drop_release", {7'b0, gnt_valid}, 8'h00);
        step(1'b0, 4'b1011, 1'b0, 1'b1);
        step(1'b0, 4'b1011, 1'b0, 1'b1);
        check("drop_ptr3", {2'b0, gnt_id, gnt}, {2'b0, 2'd3, 4'b1000});

        // Reset during BUSY clears everything; round-robin restarts at 0.
        step(1'b1, 4'b1011, 1'b0, 1'b1);
        check("rst_mid", {timeout, gnt_valid, gnt_id, gnt}, 8'h00);
        step(1'b0, 4'b1111, 1'b0, 1'b1);
        check("rr_restart", {2'b0, gnt_id, gnt}, {2'b0, 2'd0, 4'b0001});
        step(1'b0, 4'b1111, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
